// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per functional unit, one broadcast per cycle.
// Define CDB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module cdb_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 32,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [SRC_W-1:0]           cdb_src
);

  logic [NUM_REQ-1:0] hold_valid;
  logic [TAG_W-1:0]   hold_tag  [NUM_REQ];
  logic [DATA_W-1:0]  hold_data [NUM_REQ];
  logic               any_valid;
  logic [SRC_W-1:0]   winner;

  assign req_ready = ~hold_valid & {NUM_REQ{~flush}};
  assign any_valid = |hold_valid;

`ifdef CDB_RR_EN
  logic [SRC_W-1:0] rr_ptr;

  // Scan from the farthest slot back toward rr_ptr so the nearest held entry wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (hold_valid[idx]) winner = SRC_W'(idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (!flush && any_valid) begin
      rr_ptr <= (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hold_valid[k]) winner = SRC_W'(k);
    end
  end
`endif

  // A unit can never be accepted and granted on the same edge: ready implies empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_tag[i]  <= '0;
        hold_data[i] <= '0;
      end
    end else if (flush) begin
      hold_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hold_valid[i] <= 1'b1;
          hold_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
          hold_data[i]  <= req_data[i*DATA_W +: DATA_W];
        end else if (any_valid && (winner == SRC_W'(i))) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (!flush && any_valid) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= hold_tag[winner];
      cdb_data  <= hold_data[winner];
      cdb_src   <= winner;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, contention order, fairness, stall and flush.
// Expected broadcast order follows CDB_RR_EN when it is defined for the build.
module tb_cdb_arbiter;

  localparam int NUM_REQ = 5;
  localparam int TAG_W   = 3;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [2:0]                cdb_src;

  int n_cmp = 0;
  int n_err = 0;
  int src_cnt [NUM_REQ];

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int u, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    req_valid[u]                 = 1'b1;
    req_tag[u*TAG_W +: TAG_W]    = t;
    req_data[u*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_req;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
  endtask

  task automatic do_reset;
    rst   = 1'b1;
    flush = 1'b0;
    clear_req();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_bcast(input string tag, input int src, input logic [TAG_W-1:0] t,
                           input logic [DATA_W-1:0] d);
    chk({tag, "_valid"}, cdb_valid, 1'b1);
    chk({tag, "_src"},   cdb_src, src[2:0]);
    chk({tag, "_tag"},   cdb_tag, t);
    chk({tag, "_data"},  cdb_data, d);
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    clear_req();

    // reset then idle
    step();
    step();
    rst = 1'b0;
    chk("rst_tag",  cdb_tag,  3'd0);
    chk("rst_data", cdb_data, 32'd0);
    chk("rst_src",  cdb_src,  3'd0);
    for (int c = 0; c < 10; c++) begin
      chk("idle_valid", cdb_valid, 1'b0);
      chk("idle_ready", req_ready, 5'b11111);
      step();
    end

    // single result, two-cycle latency
    present(2, 3'd3, 32'hDEADBEEF);
    chk("single_rdy_n", req_ready[2], 1'b1);
    step();
    clear_req();
    chk("single_rdy_n1", req_ready[2], 1'b0);
    chk("single_val_n1", cdb_valid, 1'b0);
    step();
    chk_bcast("single_n2", 2, 3'd3, 32'hDEADBEEF);
    step();
    chk("single_val_n3", cdb_valid, 1'b0);
    chk("single_rdy_n3", req_ready[2], 1'b1);

    // contention: units 0,1,4 together, then 0 and 4 refilled
    do_reset();
    present(0, 3'd1, 32'h0000_00A0);
    present(1, 3'd2, 32'h0000_00A1);
    present(4, 3'd7, 32'h0000_00A4);
    step();
    clear_req();
    chk("cont_rdy", req_ready, 5'b01100);
    step();
    chk_bcast("cont_b0", 0, 3'd1, 32'h0000_00A0);
    step();
    chk_bcast("cont_b1", 1, 3'd2, 32'h0000_00A1);
    step();
    chk_bcast("cont_b2", 4, 3'd7, 32'h0000_00A4);
    present(0, 3'd4, 32'h0000_00B0);
    present(4, 3'd5, 32'h0000_00B4);
    step();
    clear_req();
    chk("cont_gap", cdb_valid, 1'b0);
    step();
    chk_bcast("cont_r0", 0, 3'd4, 32'h0000_00B0);
    step();
    chk_bcast("cont_r1", 4, 3'd5, 32'h0000_00B4);
    step();
    chk("cont_end", cdb_valid, 1'b0);

    // all units continuously valid for 20 broadcasts
    do_reset();
    for (int u = 0; u < NUM_REQ; u++) begin
      present(u, u[TAG_W-1:0], 32'hA000_0000 + u);
      src_cnt[u] = 0;
    end
    step();
    step();
    for (int k = 0; k < 20; k++) begin
      int exp_src;
`ifdef CDB_RR_EN
      exp_src = k % 5;
`else
      exp_src = k % 2;
`endif
      chk("fair_valid", cdb_valid, 1'b1);
      chk("fair_src", cdb_src, exp_src[2:0]);
      chk("fair_tag", cdb_tag, exp_src[2:0]);
      chk("fair_data", cdb_data, 32'hA000_0000 + exp_src);
      if (cdb_src < NUM_REQ) src_cnt[cdb_src]++;
      step();
    end
    for (int u = 0; u < NUM_REQ; u++) begin
`ifdef CDB_RR_EN
      chk("fair_count", src_cnt[u], 4);
`else
      chk("fair_count", src_cnt[u], (u < 2) ? 10 : 0);
`endif
    end

    // asynchronous reset while broadcasting
    chk("arst_pre", cdb_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_valid", cdb_valid, 1'b0);
    chk("arst_ready", req_ready, 5'b11111);
    clear_req();
    step();
    rst = 1'b0;

    // stall: unit 1 presents a second result while its first is still held
    do_reset();
    present(0, 3'd1, 32'h0000_0000);
    present(1, 3'd5, 32'h1111_1111);
    step();
    req_valid[0] = 1'b0;
    present(1, 3'd6, 32'h2222_2222);
    chk("stall_rdy_n1", req_ready[1], 1'b0);
    step();
    chk_bcast("stall_b0", 0, 3'd1, 32'h0000_0000);
    chk("stall_rdy_n2", req_ready[1], 1'b0);
    step();
    chk_bcast("stall_b1", 1, 3'd5, 32'h1111_1111);
    chk("stall_rdy_n3", req_ready[1], 1'b1);
    step();
    clear_req();
    chk("stall_gap", cdb_valid, 1'b0);
    chk("stall_rdy_n4", req_ready[1], 1'b0);
    step();
    chk_bcast("stall_b2", 1, 3'd6, 32'h2222_2222);
    step();
    chk("stall_end", cdb_valid, 1'b0);

    // flush discards held results and any request presented during it
    do_reset();
    present(0, 3'd2, 32'h0000_0C00);
    present(3, 3'd4, 32'h0000_0C03);
    step();
    clear_req();
    flush = 1'b1;
    present(2, 3'd6, 32'h3333_3333);
    #1;
    chk("flush_rdy", req_ready, 5'b00000);
    step();
    flush = 1'b0;
    clear_req();
    #1;
    chk("flush_valid", cdb_valid, 1'b0);
    chk("flush_ready", req_ready, 5'b11111);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("flush_quiet", cdb_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the functional units behind the reservation stations: res1..res4 ALUs and the branch unit.
- Each unit deposits one completed result (ROB tag plus data) into a private holding register. The arbiter broadcasts one held result per cycle to the ROB, regfile and reservation stations.
- Sits between the ALU outputs and the CDB broadcast consumers, and obeys the ROB flush.

Parameters:
- NUM_REQ, 5, number of requesting functional units (index 4 = branch unit)
- TAG_W, 3, ROB tag width (8-entry ROB)
- DATA_W, 32, result data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  ROB flush in progress; discards all held results
- req_valid  in  NUM_REQ  per-unit result valid
- req_tag  in  NUM_REQ*TAG_W  per-unit ROB tag, unit i at bits [i*TAG_W +: TAG_W]
- req_data  in  NUM_REQ*DATA_W  per-unit result, unit i at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-unit holding register free
- cdb_valid  out  1  broadcast valid (registered)
- cdb_tag  out  TAG_W  broadcast ROB tag (registered)
- cdb_data  out  DATA_W  broadcast result (registered)
- cdb_src  out  $clog2(NUM_REQ)  index of the unit being broadcast (registered)

Behaviour:
- Reset (async, rst=1):
  - hold_valid all 0
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0
  - rr_ptr=0
- req_ready[i] = ~hold_valid[i] & ~flush (combinational).
- Accept: at a clock edge with req_valid[i] & req_ready[i], the holding register i captures tag/data and hold_valid[i] becomes 1.
  - A requester holding req_valid while not ready is stalled. It must keep its tag/data stable until ready.
- Arbitration each cycle is combinational over hold_valid:
  - The winner is the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
- Broadcast: at the edge, if any hold_valid is set and flush=0:
  - cdb_valid=1, and cdb_tag/cdb_data/cdb_src load the winner's entry.
  - hold_valid[winner] clears.
  - rr_ptr = (winner+1) mod NUM_REQ.
  - Otherwise cdb_valid=0, and tag/data/src hold their previous values.
- Latency:
  - Result presented in cycle N with ready=1 → broadcast visible in cycle N+2 when uncontended.
  - Throughput is 1 broadcast per cycle.
- No same-cycle refill: a unit granted in cycle M shows ready=1 in cycle M+1. Its new result can be accepted at the end of M+1.
- Flush (level):
  - At each edge with flush=1: all hold_valid clear, cdb_valid becomes 0, no accepts occur, rr_ptr is unchanged.
  - Flush overrides simultaneous accept and broadcast.
- All requesters valid: each unit is served at most once per NUM_REQ consecutive broadcasts (round-robin fairness).
- rr_ptr wrap: a grant to unit NUM_REQ-1 sets rr_ptr=0.
- Reset mid-broadcast: cdb_valid drops to 0 immediately (async). Held results are lost.

Optional Feature:
- Macro CDB_RR_EN.
- Defined: round-robin arbitration exactly as specified above.
- Undefined: fixed priority, lowest index wins every cycle. rr_ptr is not implemented and stays 0. The branch unit (index 4) has lowest priority and can starve under continuous ALU traffic, which is accepted.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release → cdb_valid=0, req_ready=5'b11111, and these values hold for 10 cycles.
- Single result: unit 2 presents tag=3, data=0xDEADBEEF in cycle N → cycle N+2 shows cdb_valid=1, cdb_tag=3, cdb_data=0xDEADBEEF, cdb_src=2. Cycle N+3 shows cdb_valid=0 and req_ready[2]=1.
- Contention with CDB_RR_EN: units 0,1,4 accepted in the same cycle with rr_ptr=0 → broadcast order src 0,1,4 on 3 consecutive cycles. Units 0 and 4 then refilled together with rr_ptr=0 (after grant 4) → src 0 then 4.
- Wrap fairness: all 5 units kept continuously valid for 20 cycles → each src appears exactly 4 times, in order 0,1,2,3,4 repeating.
- Stall: unit 1 holds an ungranted entry while presenting a second result → req_ready[1]=0. The second result is captured only in the cycle after unit 1's first broadcast, and data is unchanged.
- Flush: units 0 and 3 held and flush=1 for one cycle → next cycle cdb_valid=0, hold empty, req_ready=5'b11111. A request presented during the flush cycle is never broadcast.
